// File: rtl/fifo_shift_prefetch_pro_if.sv
// Handshake bundle for fifo_shift_prefetch_pro. overflow/underflow exist only
// when FIFO_SHIFT_ERR_EN is defined.
interface fifo_shift_prefetch_pro_if #(
  parameter int DATA_W  = 8,
  parameter int DEPTH_W = 11
);
  logic               flush;
  logic               wr_en;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_vld;
  logic               rd_en;
  logic               rd_vld;
  logic [DATA_W-1:0]  rd_data;
  logic [DEPTH_W:0]   level;
  logic               almost_full;
  logic               almost_empty;
`ifdef FIFO_SHIFT_ERR_EN
  logic               overflow;
  logic               underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  wr_vld, rd_vld, rd_data, level, almost_full, almost_empty, overflow, underflow
  );
  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output wr_vld, rd_vld, rd_data, level, almost_full, almost_empty, overflow, underflow
  );
`else
  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  wr_vld, rd_vld, rd_data, level, almost_full, almost_empty
  );
  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output wr_vld, rd_vld, rd_data, level, almost_full, almost_empty
  );
`endif
endinterface

// File: rtl/fifo_shift_prefetch_pro.sv
// Parametrised first-word-fall-through FIFO with fill level, almost flags and flush.
// Define FIFO_SHIFT_ERR_EN to build the sticky overflow/underflow flags.
module fifo_shift_prefetch_pro #(
  parameter int DATA_W    = 8,
  parameter int DEPTH_W   = 11,
  parameter int AFULL_TH  = (2**DEPTH_W) - 4,
  parameter int AEMPTY_TH = 4
) (
  input logic                    clk,
  input logic                    rst,
  fifo_shift_prefetch_pro_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] FULL_LVL   = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W:0] AFULL_LVL  = (DEPTH_W+1)'(AFULL_TH);
  localparam logic [DEPTH_W:0] AEMPTY_LVL = (DEPTH_W+1)'(AEMPTY_TH);
  localparam logic [DEPTH_W:0] ONE_LVL    = (DEPTH_W+1)'(1);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr;
  logic [DEPTH_W:0]   level_q, level_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_vld_q, rd_vld_d, wr_vld_q, wr_vld_d;
  logic               afull_q, afull_d, aempty_q, aempty_d;
  logic               push, pop;

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    push      = bus.wr_en & wr_vld_q & ~bus.flush;
    pop       = bus.rd_en & rd_vld_q & ~bus.flush;
    rd_addr   = pop ? rd_ptr_q + DEPTH_W'(1) : rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = rd_vld_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      rd_vld_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + DEPTH_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_W'(1);
      level_d = level_q + (DEPTH_W+1)'(push) - (DEPTH_W+1)'(pop);

      // Output register is a prefetch stage: refill on pop, bypass the write
      // when the popped word was the last one, else fetch a newly stored head.
      if (pop) begin
        if (level_q > ONE_LVL) begin
          rd_data_d = mem[rd_addr];
          rd_vld_d  = 1'b1;
        end else if (push) begin
          rd_data_d = bus.wr_data;
          rd_vld_d  = 1'b1;
        end else begin
          rd_vld_d  = 1'b0;
        end
      end else if (!rd_vld_q && level_q != '0) begin
        rd_data_d = mem[rd_addr];
        rd_vld_d  = 1'b1;
      end
    end

    wr_vld_d = (level_d != FULL_LVL);
    afull_d  = (level_d >= AFULL_LVL);
    aempty_d = (level_d <= AEMPTY_LVL);
  end

  // NOTE: the storage array has no reset; contents are meaningless until written,
  // and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      wr_vld_q  <= wr_vld_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
    end
  end

  assign bus.wr_vld       = wr_vld_q;
  assign bus.rd_vld       = rd_vld_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.level        = level_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;

`ifdef FIFO_SHIFT_ERR_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  always_comb begin
    overflow_d  = bus.flush ? 1'b0 : (overflow_q  | (bus.wr_en & ~wr_vld_q));
    underflow_d = bus.flush ? 1'b0 : (underflow_q | (bus.rd_en & ~rd_vld_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_shift_prefetch_pro.sv
// Directed self-checking bench for fifo_shift_prefetch_pro (DATA_W=8, DEPTH_W=4).
// Error-flag checks are compiled in when FIFO_SHIFT_ERR_EN is defined.
module tb_fifo_shift_prefetch_pro;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  fifo_shift_prefetch_pro_if #(.DATA_W(8), .DEPTH_W(4)) bus ();

  fifo_shift_prefetch_pro #(
    .DATA_W(8), .DEPTH_W(4), .AFULL_TH(12), .AEMPTY_TH(4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    int sent;
    int rcvd;

    rst         = 1'b1;
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    repeat (2) tick;

    // Reset state
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_wr_vld", 32'(bus.wr_vld), 32'd0);
    check("rst_rd_vld", 32'(bus.rd_vld), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_afull", 32'(bus.almost_full), 32'd0);
    check("rst_aempty", 32'(bus.almost_empty), 32'd1);
`ifdef FIFO_SHIFT_ERR_EN
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_unf", 32'(bus.underflow), 32'd0);
`endif
    rst = 1'b0;
    check("rel_wr_vld_low", 32'(bus.wr_vld), 32'd0);
    tick;
    check("rel_wr_vld_high", 32'(bus.wr_vld), 32'd1);

    // 1. three back-to-back writes, first word shows one clock later
    bus.wr_en = 1'b1; bus.wr_data = 8'h11; tick;
    check("t1_vld_edge_n", 32'(bus.rd_vld), 32'd0);
    check("t1_level1", 32'(bus.level), 32'd1);
    bus.wr_data = 8'h22; tick;
    check("t1_vld", 32'(bus.rd_vld), 32'd1);
    check("t1_data", 32'(bus.rd_data), 32'h11);
    bus.wr_data = 8'h33; tick;
    bus.wr_en = 1'b0;
    check("t1_level3", 32'(bus.level), 32'd3);
    check("t1_data_hold", 32'(bus.rd_data), 32'h11);
    bus.rd_en = 1'b1;
    tick; check("t1_pop1", 32'(bus.rd_data), 32'h22);
    tick; check("t1_pop2", 32'(bus.rd_data), 32'h33);
    check("t1_level_pop2", 32'(bus.level), 32'd1);
    tick; check("t1_empty_vld", 32'(bus.rd_vld), 32'd0);
    check("t1_empty_level", 32'(bus.level), 32'd0);
    check("t1_empty_hold", 32'(bus.rd_data), 32'h33);
    bus.rd_en = 1'b0;

    // 2. fill to full, drop writes at full, drain in order
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i); tick;
      check("t2_level", 32'(bus.level), 32'(i + 1));
      check("t2_afull", 32'(bus.almost_full), 32'(i + 1 >= 12));
      check("t2_aempty", 32'(bus.almost_empty), 32'(i + 1 <= 4));
      check("t2_wr_vld", 32'(bus.wr_vld), 32'(i != 15));
    end
    bus.wr_data = 8'hAA; tick;
    check("t2_drop_level", 32'(bus.level), 32'd16);
    check("t2_drop_wr_vld", 32'(bus.wr_vld), 32'd0);
`ifdef FIFO_SHIFT_ERR_EN
    check("t2_overflow", 32'(bus.overflow), 32'd1);
`endif
    check("t2_head", 32'(bus.rd_data), 32'h00);
    bus.wr_data = 8'hBB; bus.rd_en = 1'b1; tick;
    bus.wr_en = 1'b0;
    check("t2_fullpop_level", 32'(bus.level), 32'd15);
    check("t2_fullpop_wr_vld", 32'(bus.wr_vld), 32'd1);
    for (int i = 1; i < 16; i++) begin
      check("t2_drain_vld", 32'(bus.rd_vld), 32'd1);
      check("t2_drain_data", 32'(bus.rd_data), 32'(i));
      tick;
    end
    bus.rd_en = 1'b0;
    check("t2_drained_level", 32'(bus.level), 32'd0);
    check("t2_drained_vld", 32'(bus.rd_vld), 32'd0);

    // 3. push and pop together at level 1
    bus.wr_en = 1'b1; bus.wr_data = 8'h55; tick;
    bus.wr_en = 1'b0; tick;
    check("t3_head", 32'(bus.rd_data), 32'h55);
    bus.wr_en = 1'b1; bus.wr_data = 8'h66; bus.rd_en = 1'b1; tick;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    check("t3_level", 32'(bus.level), 32'd1);
    check("t3_vld", 32'(bus.rd_vld), 32'd1);
    check("t3_data", 32'(bus.rd_data), 32'h66);
    bus.rd_en = 1'b1; tick; bus.rd_en = 1'b0;
    check("t3_empty", 32'(bus.level), 32'd0);

    // 4. streaming with bubbles on both sides
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 2000 && rcvd < 100; cyc++) begin
      bus.wr_en   = (sent < 100) && (cyc % 4 != 3);
      bus.wr_data = 8'(sent * 7 + 3);
      bus.rd_en   = (cyc % 5 != 2);
      if (bus.rd_en && bus.rd_vld) begin
        if (q.size() == 0) check("t4_extra", 32'd1, 32'd0);
        else check("t4_data", 32'(bus.rd_data), 32'(q.pop_front()));
        rcvd++;
      end
      if (bus.wr_en && bus.wr_vld) begin
        q.push_back(bus.wr_data);
        sent++;
      end
      tick;
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    check("t4_count", 32'(rcvd), 32'd100);
    check("t4_level", 32'(bus.level), 32'd0);

    // 5. flush at level 9 with a simultaneous write
    for (int i = 0; i < 9; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'hA0 + i); tick;
    end
    bus.wr_en = 1'b0;
    check("t5_level9", 32'(bus.level), 32'd9);
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hEE; tick;
    bus.flush = 1'b0; bus.wr_en = 1'b0;
    check("t5_level", 32'(bus.level), 32'd0);
    check("t5_rd_vld", 32'(bus.rd_vld), 32'd0);
    check("t5_aempty", 32'(bus.almost_empty), 32'd1);
    check("t5_wr_vld", 32'(bus.wr_vld), 32'd1);
`ifdef FIFO_SHIFT_ERR_EN
    check("t5_ovf_clr", 32'(bus.overflow), 32'd0);
    check("t5_unf_clr", 32'(bus.underflow), 32'd0);
`endif
    bus.wr_en = 1'b1; bus.wr_data = 8'h77; tick;
    bus.wr_en = 1'b0; tick;
    check("t5_after_data", 32'(bus.rd_data), 32'h77);
    check("t5_after_level", 32'(bus.level), 32'd1);

    // 6. reset mid-burst at level 7
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'hC0 + i); tick;
    end
    check("t6_level7", 32'(bus.level), 32'd7);
    rst = 1'b1; #1;
    check("t6_rst_rd_vld", 32'(bus.rd_vld), 32'd0);
    check("t6_rst_wr_vld", 32'(bus.wr_vld), 32'd0);
    check("t6_rst_level", 32'(bus.level), 32'd0);
    check("t6_rst_data", 32'(bus.rd_data), 32'd0);
    bus.wr_en = 1'b0;
    tick;
    rst = 1'b0;
    check("t6_rel_wr_vld_low", 32'(bus.wr_vld), 32'd0);
    tick;
    check("t6_rel_wr_vld_high", 32'(bus.wr_vld), 32'd1);
    bus.rd_en = 1'b1; tick; bus.rd_en = 1'b0;
    check("t6_empty_rd_vld", 32'(bus.rd_vld), 32'd0);
    check("t6_empty_level", 32'(bus.level), 32'd0);
`ifdef FIFO_SHIFT_ERR_EN
    check("t6_underflow", 32'(bus.underflow), 32'd1);
    check("t6_no_overflow", 32'(bus.overflow), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
